// File: rtl/byte_striping_n.sv
// Round-robin word striper: one valid-qualified stream onto LANES registered output lanes.
// Latency 1 cycle; no backpressure. Optional stripe counter under BYTE_STRIPING_STRIPE_CNT_EN.
module byte_striping_n #(
    parameter  int LANES  = 4,
    parameter  int DATA_W = 32,
    localparam int LW     = $clog2(LANES) + 1
) (
    input  logic                    clk_2f,
    input  logic                    reset_L,
    input  logic                    valid_in,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [LW-1:0]           active_lanes,
    output logic [LANES*DATA_W-1:0] lane_data,
    output logic [LANES-1:0]        lane_valid,
    output logic [LW-1:0]           lane_ptr,
    output logic                    stripe_done,
    output logic                    frag_err
`ifdef BYTE_STRIPING_STRIPE_CNT_EN
    ,
    output logic [15:0]             stripe_cnt
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_lane     [LANES];
    logic [DATA_W-1:0] w_lane_nxt [LANES];
    logic [LANES-1:0]  r_vld, w_vld_nxt;
    logic [LW-1:0]     r_ptr, w_ptr_nxt;
    logic [LW-1:0]     r_act, w_act_nxt;
    logic [LW-1:0]     w_act_sel;
    logic [LW-1:0]     w_last;
    logic              r_done, w_done_nxt;
    logic              r_frag, w_frag_nxt;

    // Out-of-range lane requests fall back to using every physical lane.
    assign w_act_sel = (active_lanes == '0 || active_lanes > LW'(LANES)) ? LW'(LANES) : active_lanes;
    assign w_last    = r_act - LW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane;
        w_vld_nxt   = r_vld;
        w_ptr_nxt   = r_ptr;
        w_act_nxt   = r_act;
        w_done_nxt  = 1'b0;
        w_frag_nxt  = 1'b0;
        if (valid_in) begin
            // r_ptr is always 0 in IDLE, so the first word lands in lane 0.
            w_state_nxt = S_RUN;
            for (int i = 0; i < LANES; i++) begin
                if (r_ptr == LW'(i)) begin
                    w_lane_nxt[i] = data_in;
                    w_vld_nxt[i]  = 1'b1;
                end
            end
            if (r_ptr == w_last) begin
                w_ptr_nxt  = '0;
                w_done_nxt = 1'b1;
            end else begin
                w_ptr_nxt = r_ptr + LW'(1);
            end
        end else begin
            w_state_nxt = S_IDLE;
            w_vld_nxt   = '0;
            w_ptr_nxt   = '0;
            if (r_state == S_RUN) begin
                w_frag_nxt = (r_ptr != '0);
            end else begin
                w_act_nxt = w_act_sel;
            end
        end
    end

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            r_state <= S_IDLE;
            for (int i = 0; i < LANES; i++) begin
                r_lane[i] <= '0;
            end
            r_vld  <= '0;
            r_ptr  <= '0;
            r_act  <= LW'(LANES);
            r_done <= 1'b0;
            r_frag <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_lane  <= w_lane_nxt;
            r_vld   <= w_vld_nxt;
            r_ptr   <= w_ptr_nxt;
            r_act   <= w_act_nxt;
            r_done  <= w_done_nxt;
            r_frag  <= w_frag_nxt;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane_out
        assign lane_data[g*DATA_W +: DATA_W] = r_lane[g];
    end

    assign lane_valid  = r_vld;
    assign lane_ptr    = r_ptr;
    assign stripe_done = r_done;
    assign frag_err    = r_frag;

`ifdef BYTE_STRIPING_STRIPE_CNT_EN
    logic [15:0] r_cnt;

    // Counted on the same edge that raises stripe_done, saturating at all-ones.
    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            r_cnt <= '0;
        end else if (w_done_nxt && r_cnt != 16'hFFFF) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    assign stripe_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_byte_striping_n.sv
// Table-driven bench for byte_striping_n (LANES=4, DATA_W=8); expected records queued at drive time.
module tb_byte_striping_n;

    localparam int LANES  = 4;
    localparam int DATA_W = 8;
    localparam int LW     = 3;

    logic                    clk_2f       = 1'b0;
    logic                    reset_L      = 1'b0;
    logic                    valid_in     = 1'b0;
    logic [DATA_W-1:0]       data_in      = '0;
    logic [LW-1:0]           active_lanes = 3'd4;
    logic [LANES*DATA_W-1:0] lane_data;
    logic [LANES-1:0]        lane_valid;
    logic [LW-1:0]           lane_ptr;
    logic                    stripe_done;
    logic                    frag_err;
`ifdef BYTE_STRIPING_STRIPE_CNT_EN
    logic [15:0]             stripe_cnt;
`endif

    byte_striping_n #(.LANES(LANES), .DATA_W(DATA_W)) dut (
        .clk_2f       (clk_2f),
        .reset_L      (reset_L),
        .valid_in     (valid_in),
        .data_in      (data_in),
        .active_lanes (active_lanes),
        .lane_data    (lane_data),
        .lane_valid   (lane_valid),
        .lane_ptr     (lane_ptr),
        .stripe_done  (stripe_done),
        .frag_err     (frag_err)
`ifdef BYTE_STRIPING_STRIPE_CNT_EN
        ,
        .stripe_cnt   (stripe_cnt)
`endif
    );

    always #5 clk_2f = ~clk_2f;

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [7:0]  dat;
        logic [2:0]  act;
        logic [31:0] e_data;
        logic [3:0]  e_vld;
        logic [2:0]  e_ptr;
        logic        e_done;
        logic        e_frag;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   e_cnt   = 0;
    int   row     = 0;

    function automatic vec_t mk(logic r, logic vl, logic [7:0] d, logic [2:0] a,
                                logic [31:0] ed, logic [3:0] ev, logic [2:0] ep,
                                logic dn, logic fr);
        vec_t v;
        v.rst_n = r;  v.vld = vl;  v.dat = d;  v.act = a;
        v.e_data = ed; v.e_vld = ev; v.e_ptr = ep; v.e_done = dn; v.e_frag = fr;
        return v;
    endfunction

    task automatic step(input vec_t v);
        vec_t e;
        reset_L      = v.rst_n;
        valid_in     = v.vld;
        data_in      = v.dat;
        active_lanes = v.act;
        sb.push_back(v);
        @(posedge clk_2f);
        #1;
        e = sb.pop_front();
        if (!e.rst_n) e_cnt = 0;
        else if (e.e_done && e_cnt < 65535) e_cnt++;
        n_tests++;
        if ({lane_data, lane_valid, lane_ptr, stripe_done, frag_err} !==
            {e.e_data, e.e_vld, e.e_ptr, e.e_done, e.e_frag}) begin
            n_fail++;
            $display("FAIL row%0d outputs: got data=%h vld=%b ptr=%0d done=%b frag=%b, expected data=%h vld=%b ptr=%0d done=%b frag=%b",
                     row, lane_data, lane_valid, lane_ptr, stripe_done, frag_err,
                     e.e_data, e.e_vld, e.e_ptr, e.e_done, e.e_frag);
        end
`ifdef BYTE_STRIPING_STRIPE_CNT_EN
        n_tests++;
        if (stripe_cnt !== 16'(e_cnt)) begin
            n_fail++;
            $display("FAIL row%0d stripe_cnt: got %0d, expected %0d", row, stripe_cnt, e_cnt);
        end
`endif
        row++;
    endtask

    initial begin
        // Reset, then 4-lane striping of 0x11..0x88.
        tbl.push_back(mk(0, 0, 8'h00, 3'd4, 32'h00000000, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd4, 32'h00000000, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h11, 3'd4, 32'h00000011, 4'b0001, 3'd1, 0, 0));
        tbl.push_back(mk(1, 1, 8'h22, 3'd4, 32'h00002211, 4'b0011, 3'd2, 0, 0));
        tbl.push_back(mk(1, 1, 8'h33, 3'd4, 32'h00332211, 4'b0111, 3'd3, 0, 0));
        tbl.push_back(mk(1, 1, 8'h44, 3'd4, 32'h44332211, 4'b1111, 3'd0, 1, 0));
        tbl.push_back(mk(1, 1, 8'h55, 3'd4, 32'h44332255, 4'b1111, 3'd1, 0, 0));
        tbl.push_back(mk(1, 1, 8'h66, 3'd4, 32'h44336655, 4'b1111, 3'd2, 0, 0));
        tbl.push_back(mk(1, 1, 8'h77, 3'd4, 32'h44776655, 4'b1111, 3'd3, 0, 0));
        tbl.push_back(mk(1, 1, 8'h88, 3'd4, 32'h88776655, 4'b1111, 3'd0, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd4, 32'h88776655, 4'b0000, 3'd0, 0, 0));
        // Fresh reset, 2 active lanes.
        tbl.push_back(mk(0, 0, 8'h00, 3'd2, 32'h00000000, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd2, 32'h00000000, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h0A, 3'd2, 32'h0000000A, 4'b0001, 3'd1, 0, 0));
        tbl.push_back(mk(1, 1, 8'h0B, 3'd2, 32'h00000B0A, 4'b0011, 3'd0, 1, 0));
        tbl.push_back(mk(1, 1, 8'h0C, 3'd2, 32'h00000B0C, 4'b0011, 3'd1, 0, 0));
        tbl.push_back(mk(1, 1, 8'h0D, 3'd2, 32'h00000D0C, 4'b0011, 3'd0, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd4, 32'h00000D0C, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd4, 32'h00000D0C, 4'b0000, 3'd0, 0, 0));
        // Partial stripe of 3 words, then idle.
        tbl.push_back(mk(1, 1, 8'h01, 3'd4, 32'h00000D01, 4'b0001, 3'd1, 0, 0));
        tbl.push_back(mk(1, 1, 8'h02, 3'd4, 32'h00000201, 4'b0011, 3'd2, 0, 0));
        tbl.push_back(mk(1, 1, 8'h03, 3'd4, 32'h00030201, 4'b0111, 3'd3, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd4, 32'h00030201, 4'b0000, 3'd0, 0, 1));
        tbl.push_back(mk(1, 0, 8'h00, 3'd4, 32'h00030201, 4'b0000, 3'd0, 0, 0));
        // Lane-count change mid-stream is ignored until the next idle cycle.
        tbl.push_back(mk(1, 1, 8'h04, 3'd4, 32'h00030204, 4'b0001, 3'd1, 0, 0));
        tbl.push_back(mk(1, 1, 8'h05, 3'd2, 32'h00030504, 4'b0011, 3'd2, 0, 0));
        tbl.push_back(mk(1, 1, 8'h06, 3'd2, 32'h00060504, 4'b0111, 3'd3, 0, 0));
        tbl.push_back(mk(1, 1, 8'h07, 3'd2, 32'h07060504, 4'b1111, 3'd0, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd2, 32'h07060504, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd2, 32'h07060504, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h08, 3'd2, 32'h07060508, 4'b0001, 3'd1, 0, 0));
        tbl.push_back(mk(1, 1, 8'h09, 3'd2, 32'h07060908, 4'b0011, 3'd0, 1, 0));
        // active_lanes=0 behaves as 4 lanes.
        tbl.push_back(mk(1, 0, 8'h00, 3'd0, 32'h07060908, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd0, 32'h07060908, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h0A, 3'd0, 32'h0706090A, 4'b0001, 3'd1, 0, 0));
        tbl.push_back(mk(1, 1, 8'h0B, 3'd0, 32'h07060B0A, 4'b0011, 3'd2, 0, 0));
        tbl.push_back(mk(1, 1, 8'h0C, 3'd0, 32'h070C0B0A, 4'b0111, 3'd3, 0, 0));
        tbl.push_back(mk(1, 1, 8'h0D, 3'd0, 32'h0D0C0B0A, 4'b1111, 3'd0, 1, 0));
        // active_lanes=7 behaves as 4 lanes.
        tbl.push_back(mk(1, 0, 8'h00, 3'd7, 32'h0D0C0B0A, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd7, 32'h0D0C0B0A, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h01, 3'd7, 32'h0D0C0B01, 4'b0001, 3'd1, 0, 0));
        tbl.push_back(mk(1, 1, 8'h02, 3'd7, 32'h0D0C0201, 4'b0011, 3'd2, 0, 0));
        tbl.push_back(mk(1, 1, 8'h03, 3'd7, 32'h0D030201, 4'b0111, 3'd3, 0, 0));
        tbl.push_back(mk(1, 1, 8'h04, 3'd7, 32'h04030201, 4'b1111, 3'd0, 1, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd4, 32'h04030201, 4'b0000, 3'd0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 3'd4, 32'h04030201, 4'b0000, 3'd0, 0, 0));
        foreach (tbl[i]) step(tbl[i]);

        // Reset after 2 of 4 words: no frag_err, lane count returns to LANES.
        step(mk(1, 1, 8'h05, 3'd4, 32'h04030205, 4'b0001, 3'd1, 0, 0));
        step(mk(1, 1, 8'h06, 3'd4, 32'h04030605, 4'b0011, 3'd2, 0, 0));
        step(mk(0, 1, 8'h07, 3'd1, 32'h00000000, 4'b0000, 3'd0, 0, 0));
        step(mk(1, 1, 8'h21, 3'd1, 32'h00000021, 4'b0001, 3'd1, 0, 0));
        step(mk(1, 0, 8'h00, 3'd1, 32'h00000021, 4'b0000, 3'd0, 0, 1));
        // Single active lane: every word completes a stripe.
        step(mk(1, 0, 8'h00, 3'd1, 32'h00000021, 4'b0000, 3'd0, 0, 0));
        step(mk(1, 1, 8'h31, 3'd1, 32'h00000031, 4'b0001, 3'd0, 1, 0));
        step(mk(1, 1, 8'h32, 3'd1, 32'h00000032, 4'b0001, 3'd0, 1, 0));
        step(mk(1, 0, 8'h00, 3'd3, 32'h00000032, 4'b0000, 3'd0, 0, 0));
        // Three lanes: wrap at a non-power-of-two count, lane 3 never written.
        step(mk(1, 0, 8'h00, 3'd3, 32'h00000032, 4'b0000, 3'd0, 0, 0));
        step(mk(1, 1, 8'h41, 3'd3, 32'h00000041, 4'b0001, 3'd1, 0, 0));
        step(mk(1, 1, 8'h42, 3'd3, 32'h00004241, 4'b0011, 3'd2, 0, 0));
        step(mk(1, 1, 8'h43, 3'd3, 32'h00434241, 4'b0111, 3'd0, 1, 0));
        step(mk(1, 1, 8'h44, 3'd3, 32'h00434244, 4'b0111, 3'd1, 0, 0));
        step(mk(1, 1, 8'h45, 3'd3, 32'h00434544, 4'b0111, 3'd2, 0, 0));
        step(mk(1, 0, 8'h00, 3'd3, 32'h00434544, 4'b0000, 3'd0, 0, 1));
        step(mk(1, 0, 8'h00, 3'd3, 32'h00434544, 4'b0000, 3'd0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/byte_striping_n.md
Name: byte_striping_n

Overview:
- Parametrised successor of the two-lane byte striper.
- Distributes a single valid-qualified word stream at clk_2f onto LANES parallel output lanes in strict round-robin order.
- The number of active lanes is selectable at runtime.
- All outputs are registered, and the block reports stripe completion and fragmented stripes.
- Sits between the serial-side word source and the per-lane low-rate paths (paired with the future un-striping block).

Parameters:
- LANES, 4, number of physical output lanes; legal 2..8.
- DATA_W, 32, word width in bits; legal 8..64.
- LW, $clog2(LANES)+1, width of active_lanes and lane_ptr; derived, not overridden.

Ports:
- clk_2f  in  1  high-rate clock; all logic on its rising edge.
- reset_L  in  1  synchronous active-low reset, sampled on rising clk_2f.
- valid_in  in  1  data_in qualifier.
- data_in  in  DATA_W  input word.
- active_lanes  in  LW  requested lane count (1..LANES); sampled only while idle.
- lane_data  out  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- lane_valid  out  LANES  per-lane valid flag.
- lane_ptr  out  LW  index of the lane receiving the next word.
- stripe_done  out  1  one-cycle pulse: last active lane loaded this cycle.
- frag_err  out  1  one-cycle pulse: stream stopped mid-stripe.

Behaviour:
- Reset (reset_L=0 at an edge): lane_data=0, lane_valid=0, lane_ptr=0, stripe_done=0, frag_err=0, act_q=LANES, state=IDLE. Reset mid-stripe discards the partial stripe with no frag_err.
- act_q (registered lane count): loaded from active_lanes on every edge where state=IDLE and valid_in=0. If active_lanes is 0 or greater than LANES, act_q=LANES. act_q is frozen while state=RUN.
- IDLE state:
  - valid_in=1 -> write data_in to lane 0, set lane_valid[0], lane_ptr=1 (or 0 if act_q=1), go to RUN.
  - The first word is loaded the same edge it arrives; a new act_q takes effect on the first word after at least one idle cycle.
- RUN state, valid_in=1:
  - Load lane[lane_ptr] <= data_in and set lane_valid[lane_ptr]=1.
  - lane_ptr increments and wraps to 0 after act_q-1.
  - When the loaded lane is act_q-1, pulse stripe_done on the next cycle's outputs (registered, same edge as the data).
- RUN state, valid_in=0:
  - Go to IDLE, lane_ptr=0, clear all lane_valid. lane_data holds its last value (not zeroed).
  - If lane_ptr!=0 at that edge (partial stripe), pulse frag_err for one cycle.
- Latency: word presented at edge k appears on lane_data/lane_valid after edge k (1 cycle).
- lane_valid[i] stays high from its first load until the stream idles; it is never set for i>=act_q.
- Lanes i>=act_q hold 0 data after reset and are never written.
- act_q=1: every word goes to lane 0; stripe_done pulses every valid cycle.
- active_lanes changes during RUN are ignored until the next idle cycle.

Optional Feature:
- Macro: BYTE_STRIPING_STRIPE_CNT_EN.
- Defined: adds output stripe_cnt [15:0], which increments on each stripe_done. It saturates at 16'hFFFF, clears on reset, and is unaffected by frag_err.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, LANES=4, active_lanes=4:
  - Stimulus: 8 consecutive words 0x11..0x88.
  - Response: lanes 0..3 = 0x11,0x22,0x33,0x44, then 0x55..0x88; stripe_done high on the cycles after 0x44 and 0x88; lane_ptr sequence 1,2,3,0,1,2,3,0.
- active_lanes=2 set during idle, 4 words 0xA..0xD:
  - Response: lane0=0xA then 0xC, lane1=0xB then 0xD; lane_valid=4'b0011; lanes 2,3 stay 0.
- 3 words then valid_in=0 (LANES=4):
  - Response: frag_err single pulse, lane_valid->0, lane_ptr->0; next word lands in lane 0.
- active_lanes changed from 4 to 2 mid-stream:
  - Response: striping continues over 4 lanes until valid_in drops; the next burst uses 2 lanes.
- reset_L=0 asserted after 2 of 4 words:
  - Response: next edge all outputs 0, no frag_err, act_q=LANES.
- active_lanes=0 and active_lanes=7 (LANES=4):
  - Response: both behave as 4 lanes.
  - With BYTE_STRIPING_STRIPE_CNT_EN: 3 full stripes -> stripe_cnt=3.
